// File: rtl/pin_bus_pkg.sv
// Shared pin-bus bit positions, byte-valid pattern and responder state encoding.
package pin_bus_pkg;

  localparam int REQ_BIT    = 0;
  localparam int WE_BIT     = 1;
  localparam int DPHASE_BIT = 2;
  localparam int ACK_BIT    = 0;
  localparam int ERR_BIT    = 1;

  localparam logic [7:0] OE_ALL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/pin_bus_mem_responder_resp_mem.sv
// Responder RAM: DEPTH x DATA_W, synchronous write through a CPU/loader mux, asynchronous read.
module resp_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_in_range
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              ld_in_range;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem [DEPTH];

  // A full-sized RAM has no out-of-range addresses, so skip the compare entirely.
  if (DEPTH >= (1 << ADDR_W)) begin : g_full
    assign cpu_in_range = 1'b1;
    assign ld_in_range  = 1'b1;
  end else begin : g_part
    localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);
    assign cpu_in_range = (cpu_addr < LIM);
    assign ld_in_range  = (ld_addr < LIM);
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ld_addr[AW-1:0];
    wr_data = ld_data;
    if (cpu_we && cpu_in_range) begin
      wr_en   = 1'b1;
      wr_addr = cpu_addr[AW-1:0];
      wr_data = cpu_wdata;
    end else if (ld_we && ld_in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = cpu_in_range ? mem[cpu_addr[AW-1:0]] : '0;

endmodule

// File: rtl/pin_bus_mem_responder.sv
// Memory-side responder for the cpuhandler pin bus: decodes CPU requests, serves them from resp_mem.
// Optional PIN_CONTENTION_CHK_EN adds a sticky contention_err output.
module pin_bus_mem_responder
  import pin_bus_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] cpu_uo,
  input  logic [7:0] cpu_uio_out,
  input  logic [7:0] cpu_uio_oe,
  output logic [7:0] cpu_ui,
  output logic [7:0] cpu_uio_in,
  input  logic       ld_we,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       busy
`ifdef PIN_CONTENTION_CHK_EN
  ,
  output logic       contention_err
`endif
);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              err_q;
  logic [7:0]        uio_in_q;
  logic              busy_q;

  logic              req;
  logic              we;
  logic              dphase;
  logic              oe_ok;
  logic              addr_byte;
  logic              data_byte;
  logic              cpu_wr;
  logic              in_range;
  logic [DATA_W-1:0] rd_data;
  logic              unused_bits;

  assign req       = cpu_uo[REQ_BIT];
  assign we        = cpu_uo[WE_BIT];
  assign dphase    = cpu_uo[DPHASE_BIT];
  assign oe_ok     = (cpu_uio_oe == OE_ALL);
  assign addr_byte = req && !dphase && oe_ok;
  assign data_byte = req && dphase && oe_ok;
  assign cpu_wr    = ena && (state == WDATA) && data_byte;

  assign unused_bits = &{1'b0, cpu_uo[7:3]};

  // Loader access is only granted while the FSM is idle, so it never collides with a CPU write.
  resp_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk          (clk),
    .cpu_we       (cpu_wr),
    .cpu_addr     (addr_q),
    .cpu_wdata    (cpu_uio_out[DATA_W-1:0]),
    .ld_we        (ld_we && !busy_q),
    .ld_addr      (ld_addr[ADDR_W-1:0]),
    .ld_data      (ld_data[DATA_W-1:0]),
    .rd_data      (rd_data),
    .cpu_in_range (in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      uio_in_q <= '0;
      busy_q   <= 1'b0;
    end else if (!ena) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      uio_in_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      uio_in_q <= '0;
      case (state)
        IDLE: begin
          if (addr_byte) begin
            busy_q <= 1'b1;
            if (we) begin
              state <= WDATA;
            end else begin
              state <= RWAIT;
              cnt   <= 4'(READ_LAT - 1);
            end
          end
        end
        WDATA: begin
          if (!req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (data_byte) begin
            state <= ACK;
          end
        end
        RWAIT: begin
          if (!req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == 4'd0) begin
            state <= ACK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          // Outputs lag the state by one edge; the edge that sees req low clears them.
          if (!req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            ack_q    <= 1'b1;
            err_q    <= !in_range;
            uio_in_q <= we_q ? 8'h00 : 8'(rdata_q);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ena && (state == IDLE) && addr_byte) begin
      addr_q <= cpu_uio_out[ADDR_W-1:0];
      we_q   <= we;
    end
    if ((state == RWAIT) && (cnt == 4'd0)) rdata_q <= rd_data;
  end

  always_comb begin
    cpu_ui          = '0;
    cpu_ui[ACK_BIT] = ack_q;
    cpu_ui[ERR_BIT] = err_q;
  end

  assign cpu_uio_in = uio_in_q;
  assign busy       = busy_q;

`ifdef PIN_CONTENTION_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_err <= 1'b0;
    end else if (ack_q && !we_q && (cpu_uio_oe != 8'h00)) begin
      contention_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pin_bus_mem_responder.sv
// Bench for pin_bus_mem_responder: directed vector table, multi-cycle corner sequences and
// random traffic against a flat-array memory model.
module tb_pin_bus_mem_responder;

  localparam int DEPTH = 128;
  localparam int RL    = 3;

  localparam int OP_LD = 0;
  localparam int OP_WR = 1;
  localparam int OP_RD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] cpu_uo;
  logic [7:0] cpu_uio_out;
  logic [7:0] cpu_uio_oe;
  logic [7:0] cpu_ui;
  logic [7:0] cpu_uio_in;
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       busy;
`ifdef PIN_CONTENTION_CHK_EN
  logic       contention_err;
`endif

  pin_bus_mem_responder #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .DEPTH    (DEPTH),
    .READ_LAT (RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .cpu_uo      (cpu_uo),
    .cpu_uio_out (cpu_uio_out),
    .cpu_uio_oe  (cpu_uio_oe),
    .cpu_ui      (cpu_ui),
    .cpu_uio_in  (cpu_uio_in),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .busy        (busy)
`ifdef PIN_CONTENTION_CHK_EN
    ,
    .contention_err (contention_err)
`endif
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] model [256];

  typedef struct {
    int         op;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic req, input logic we, input logic dph,
                         input logic [7:0] val, input logic [7:0] oe);
    cpu_uo      = {5'b0, dph, we, req};
    cpu_uio_out = val;
    cpu_uio_oe  = oe;
  endtask

  function automatic logic in_rng(input logic [7:0] a);
    return int'(a) < DEPTH;
  endfunction

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
    if (in_rng(a)) model[a] = d;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    while (!cpu_ui[0] && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // Full read transaction: returns data/err at first ack, ack after two held cycles, ack after req drop.
  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d, output logic e,
                          output int lat, output logic held, output logic dropped);
    set_bus(1'b1, 1'b0, 1'b0, a, 8'hFF);
    step();
    cpu_uio_oe  = 8'h00;
    cpu_uio_out = 8'h00;
    wait_ack(lat);
    d = cpu_uio_in;
    e = cpu_ui[1];
    step();
    step();
    held = cpu_ui[0];
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    dropped = cpu_ui[0];
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, output logic e,
                           output logic [7:0] rd, output int lat, output logic dropped);
    set_bus(1'b1, 1'b1, 1'b0, a, 8'hFF);
    step();
    set_bus(1'b1, 1'b1, 1'b1, d, 8'hFF);
    step();
    cpu_uio_oe = 8'h00;
    wait_ack(lat);
    e  = cpu_ui[1];
    rd = cpu_uio_in;
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    dropped = cpu_ui[0];
    if (in_rng(a)) model[a] = d;
  endtask

  initial begin
    logic [7:0] d, a, x;
    logic       e, held, dropped;
    int         lat;

    rst_n = 1'b0;
    ena   = 1'b1;
    ld_we = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    foreach (model[i]) model[i] = 8'h00;
    #1;
    check8("reset_cpu_ui", cpu_ui, 8'h00);
    step();
    step();
    check8("reset_uio_in", cpu_uio_in, 8'h00);
    check1("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) load(8'(i), 8'($urandom_range(0, 255)));

    vecs[0]  = '{OP_LD, 8'h10, 8'h3C, 8'h00, 1'b0};
    vecs[1]  = '{OP_RD, 8'h10, 8'h00, 8'h3C, 1'b0};
    vecs[2]  = '{OP_WR, 8'h22, 8'hA5, 8'h00, 1'b0};
    vecs[3]  = '{OP_RD, 8'h22, 8'h00, 8'hA5, 1'b0};
    vecs[4]  = '{OP_RD, 8'h80, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{OP_WR, 8'h90, 8'h77, 8'h00, 1'b1};
    vecs[6]  = '{OP_RD, 8'h10, 8'h00, 8'h3C, 1'b0};
    vecs[7]  = '{OP_LD, 8'h7F, 8'hE1, 8'h00, 1'b0};
    vecs[8]  = '{OP_RD, 8'h7F, 8'h00, 8'hE1, 1'b0};
    vecs[9]  = '{OP_LD, 8'hFF, 8'h12, 8'h00, 1'b0};
    vecs[10] = '{OP_RD, 8'h7F, 8'h00, 8'hE1, 1'b0};
    vecs[11] = '{OP_RD, 8'hFF, 8'h00, 8'h00, 1'b1};

    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_LD: load(vecs[i].addr, vecs[i].data);
        OP_WR: begin
          cpu_write(vecs[i].addr, vecs[i].data, e, d, lat, dropped);
          checki($sformatf("vec%0d_wr_lat", i), lat, 1);
          check1($sformatf("vec%0d_wr_err", i), e, vecs[i].exp_err);
          check8($sformatf("vec%0d_wr_uio", i), d, 8'h00);
          check1($sformatf("vec%0d_wr_drop", i), dropped, 1'b0);
        end
        default: begin
          cpu_read(vecs[i].addr, d, e, lat, held, dropped);
          checki($sformatf("vec%0d_rd_lat", i), lat, RL + 1);
          check8($sformatf("vec%0d_rd_data", i), d, vecs[i].exp_data);
          check1($sformatf("vec%0d_rd_err", i), e, vecs[i].exp_err);
          check1($sformatf("vec%0d_rd_hold", i), held, 1'b1);
          check1($sformatf("vec%0d_rd_drop", i), dropped, 1'b0);
        end
      endcase
    end

    // Dropping req in WDATA aborts without ack or write.
    set_bus(1'b1, 1'b1, 1'b0, 8'h22, 8'hFF);
    step();
    set_bus(1'b0, 1'b1, 1'b1, 8'h11, 8'hFF);
    step();
    check1("abort_wdata_busy", busy, 1'b0);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();
    check1("abort_wdata_ack", cpu_ui[0], 1'b0);
    cpu_read(8'h22, d, e, lat, held, dropped);
    check8("abort_wdata_ram", d, 8'hA5);

    // Write data byte with partial oe stalls in WDATA until oe goes all-ones.
    set_bus(1'b1, 1'b1, 1'b0, 8'h30, 8'hFF);
    step();
    set_bus(1'b1, 1'b1, 1'b1, 8'h5A, 8'h0F);
    repeat (3) step();
    check1("oe_wait_ack", cpu_ui[0], 1'b0);
    check1("oe_wait_busy", busy, 1'b1);
    cpu_uio_oe = 8'hFF;
    step();
    cpu_uio_oe = 8'h00;
    step();
    check1("oe_wait_ack_after", cpu_ui[0], 1'b1);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    model[8'h30] = 8'h5A;
    cpu_read(8'h30, d, e, lat, held, dropped);
    check8("oe_wait_ram", d, 8'h5A);

    // Async reset mid-RWAIT, and again while ack is up.
    set_bus(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF);
    step();
    cpu_uio_oe = 8'h00;
    step();
    rst_n = 1'b0;
    #1;
    check1("rst_rwait_busy", busy, 1'b0);
    check8("rst_rwait_ui", cpu_ui, 8'h00);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    set_bus(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF);
    step();
    cpu_uio_oe = 8'h00;
    wait_ack(lat);
    check8("pre_rst_ack_data", cpu_uio_in, 8'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    check8("rst_ack_ui", cpu_ui, 8'h00);
    check8("rst_ack_uio_in", cpu_uio_in, 8'h00);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    cpu_read(8'h10, d, e, lat, held, dropped);
    check8("ram_survives_reset", d, 8'h3C);

    // Loader ignored while busy; same-cycle capture plus load both take effect.
    set_bus(1'b1, 1'b0, 1'b0, 8'h41, 8'hFF);
    step();
    cpu_uio_oe = 8'h00;
    ld_we   = 1'b1;
    ld_addr = 8'h41;
    ld_data = ~model[8'h41];
    step();
    ld_we = 1'b0;
    wait_ack(lat);
    check8("ld_busy_rd", cpu_uio_in, model[8'h41]);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    cpu_read(8'h41, d, e, lat, held, dropped);
    check8("ld_busy_ignored", d, model[8'h41]);
    x = 8'($urandom_range(0, 255));
    set_bus(1'b1, 1'b0, 1'b0, 8'h42, 8'hFF);
    ld_we   = 1'b1;
    ld_addr = 8'h43;
    ld_data = x;
    step();
    ld_we = 1'b0;
    model[8'h43] = x;
    cpu_uio_oe = 8'h00;
    wait_ack(lat);
    checki("same_cycle_lat", lat, RL + 1);
    check8("same_cycle_rd", cpu_uio_in, model[8'h42]);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    cpu_read(8'h43, d, e, lat, held, dropped);
    check8("same_cycle_ld", d, x);

    // ena low mid-read aborts; no late ack once ena returns.
    set_bus(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF);
    step();
    cpu_uio_oe = 8'h00;
    ena = 1'b0;
    step();
    check1("ena_abort_busy", busy, 1'b0);
    ena = 1'b1;
    repeat (RL + 3) step();
    check1("ena_abort_ack", cpu_ui[0], 1'b0);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

`ifdef PIN_CONTENTION_CHK_EN
    check1("contention_idle", contention_err, 1'b0);
    set_bus(1'b1, 1'b0, 1'b0, 8'h10, 8'hFF);
    step();
    cpu_uio_oe = 8'h00;
    wait_ack(lat);
    cpu_uio_oe = 8'hFF;
    step();
    check1("contention_set", contention_err, 1'b1);
    set_bus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step();
    check1("contention_sticky", contention_err, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("contention_rst", contention_err, 1'b0);
    step();
    rst_n = 1'b1;
    step();
`endif

    for (int n = 0; n < 300; n++) begin
      a = 8'($urandom_range(0, 255));
      x = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: load(a, x);
        1: begin
          cpu_write(a, x, e, d, lat, dropped);
          check1($sformatf("rnd%0d_wr_err", n), e, !in_rng(a));
        end
        default: begin
          cpu_read(a, d, e, lat, held, dropped);
          checki($sformatf("rnd%0d_rd_lat", n), lat, RL + 1);
          check8($sformatf("rnd%0d_rd_data", n), d, in_rng(a) ? model[a] : 8'h00);
          check1($sformatf("rnd%0d_rd_err", n), e, !in_rng(a));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
